// File: rtl/cmpb_resolve_if.sv
// cmpb_resolve_if
// Bundles the instruction handshake (execute -> resolve unit) and the
// redirect handshake (resolve unit -> fetch).
//   instr_valid / instr_ready / instr / instr_addr : instruction channel
//   redirect_valid / redirect_ready / redirect_addr : redirect channel
// modport slave  : the resolve unit (consumes instructions, produces redirects)
// modport master : the environment (produces instructions, accepts redirects)
interface cmpb_resolve_if #(
  parameter int ADDR_W = 12
);
  logic              instr_valid;
  logic              instr_ready;
  logic [15:0]       instr;
  logic [ADDR_W-1:0] instr_addr;
  logic              redirect_valid;
  logic              redirect_ready;
  logic [ADDR_W-1:0] redirect_addr;

  modport slave (
    input  instr_valid, instr, instr_addr, redirect_ready,
    output instr_ready, redirect_valid, redirect_addr
  );

  modport master (
    output instr_valid, instr, instr_addr, redirect_ready,
    input  instr_ready, redirect_valid, redirect_addr
  );
endinterface

// File: rtl/cmpb_resolve_unit.sv
// cmpb_resolve_unit
// Compare-and-branch resolution for the execute stage. Holds the {S,Z,V,C}
// flag register, evaluates one of eight branch conditions on each accepted
// branch, raises a registered redirect that is held until fetch takes it,
// then discards SQUASH_N wrong-path instructions. Keeps saturating counts of
// resolved and taken branches.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   flag_we/flag_in flag register load (also bypassed into the accept cycle)
//   bus             instruction + redirect handshakes (slave modport)
//   resolved        1-cycle pulse after a branch is accepted and evaluated
//   resolved_taken  condition outcome, qualified by resolved
//   squashed        1-cycle pulse after a wrong-path instruction is dropped
//   branch_count    saturating count of resolved branches
//   taken_count     saturating count of taken branches
module cmpb_resolve_unit #(
  parameter int ADDR_W   = 12,
  parameter int DISP_W   = 8,
  parameter int SQUASH_N = 2,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flag_we,
  input  logic [3:0]        flag_in,
  cmpb_resolve_if.slave     bus,
  output logic              resolved,
  output logic              resolved_taken,
  output logic              squashed,
  output logic [CNT_W-1:0]  branch_count,
  output logic [CNT_W-1:0]  taken_count
);

  localparam int SQ_W = (SQUASH_N < 1) ? 1 : $clog2(SQUASH_N + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_SQUASH = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Condition table; flag vector is {S,Z,V,C}.
  function automatic logic cond_eval(input logic [2:0] cond, input logic [3:0] f);
    logic s, z, v, c;
    s = f[3];
    z = f[2];
    v = f[1];
    c = f[0];
    case (cond)
      3'b000:  return z;
      3'b001:  return s ^ v;
      3'b010:  return z | (s ^ v);
      3'b011:  return ~z;
      3'b100:  return c;
      3'b101:  return c | z;
      3'b110:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    return (&val) ? val : val + CNT_W'(1);
  endfunction

  logic [3:0]              flags;
  logic [3:0]              flags_eff;
  logic                    accept;
  logic                    is_branch;
  logic                    taken;
  logic signed [DISP_W-1:0] disp;
  logic signed [ADDR_W-1:0] disp_ext;
  logic [ADDR_W-1:0]       target;
  logic [SQ_W-1:0]         sq_cnt;

  logic                    resolved_p1;
  logic                    resolved_taken_p1;
  logic                    squashed_p1;
  logic [ADDR_W-1:0]       redirect_addr_p1;
  logic [CNT_W-1:0]        branch_count_p1;
  logic [CNT_W-1:0]        taken_count_p1;

  // ---- stage 0: decode and evaluate the presented instruction ----
  assign accept    = bus.instr_valid & bus.instr_ready;
  assign is_branch = (bus.instr[15:14] == 2'b10) && (bus.instr[13:11] == 3'b111);
  // Flags written this very cycle take precedence over the stored copy.
  assign flags_eff = flag_we ? flag_in : flags;
  assign taken     = cond_eval(bus.instr[10:8], flags_eff);
  assign disp      = bus.instr[DISP_W-1:0];
  assign disp_ext  = ADDR_W'(disp);
  // Unsigned add of the sign-extended displacement; carry out is dropped so
  // the target wraps modulo 2^ADDR_W.
  assign target    = bus.instr_addr + ADDR_W'(1) + disp_ext;

  // ---- FSM: state register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---- FSM: next-state logic ----
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept && is_branch && taken) begin
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (bus.redirect_ready) begin
          state_nxt = (SQUASH_N == 0) ? ST_IDLE : ST_SQUASH;
        end
      end
      ST_SQUASH: begin
        if (accept && (sq_cnt <= SQ_W'(1))) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  always_comb begin
    bus.instr_ready    = 1'b1;
    bus.redirect_valid = 1'b0;
    case (state)
      ST_HOLD: begin
        bus.instr_ready    = 1'b0;
        bus.redirect_valid = 1'b1;
      end
      default: begin
        bus.instr_ready    = 1'b1;
        bus.redirect_valid = 1'b0;
      end
    endcase
  end

  // Flag register follows every write regardless of state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags <= 4'b0000;
    end else if (flag_we) begin
      flags <= flag_in;
    end
  end

  // Wrong-path counter: armed when fetch takes the redirect, counts down on
  // each instruction accepted while squashing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sq_cnt <= '0;
    end else if ((state == ST_HOLD) && bus.redirect_ready) begin
      sq_cnt <= SQ_W'(SQUASH_N);
    end else if ((state == ST_SQUASH) && accept && (sq_cnt != '0)) begin
      sq_cnt <= sq_cnt - SQ_W'(1);
    end
  end

  // ---- stage 1: registered resolution results ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resolved_p1       <= 1'b0;
      resolved_taken_p1 <= 1'b0;
      squashed_p1       <= 1'b0;
      redirect_addr_p1  <= '0;
      branch_count_p1   <= '0;
      taken_count_p1    <= '0;
    end else begin
      resolved_p1       <= 1'b0;
      resolved_taken_p1 <= 1'b0;
      squashed_p1       <= (state == ST_SQUASH) && accept;
      if ((state == ST_IDLE) && accept && is_branch) begin
        resolved_p1       <= 1'b1;
        resolved_taken_p1 <= taken;
        branch_count_p1   <= sat_inc(branch_count_p1);
        if (taken) begin
          taken_count_p1   <= sat_inc(taken_count_p1);
          // Only loaded on entry to HOLD, so it stays constant while held.
          redirect_addr_p1 <= target;
        end
      end
    end
  end

  assign bus.redirect_addr = redirect_addr_p1;
  assign resolved          = resolved_p1;
  assign resolved_taken    = resolved_taken_p1;
  assign squashed          = squashed_p1;
  assign branch_count      = branch_count_p1;
  assign taken_count       = taken_count_p1;

endmodule

// File: tb/tb_cmpb_resolve_unit.sv
// Directed bench for cmpb_resolve_unit (SQUASH_N=2, CNT_W=4 so that
// counter saturation is reachable with a short sequence).
module tb_cmpb_resolve_unit;

  logic       clk;
  logic       rst;
  logic       flag_we;
  logic [3:0] flag_in;
  logic       resolved;
  logic       resolved_taken;
  logic       squashed;
  logic [3:0] branch_count;
  logic [3:0] taken_count;

  int total;
  int bad;

  cmpb_resolve_if #(.ADDR_W(12)) bus ();

  cmpb_resolve_unit #(
    .ADDR_W(12), .DISP_W(8), .SQUASH_N(2), .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flag_we(flag_we),
    .flag_in(flag_in),
    .bus(bus.slave),
    .resolved(resolved),
    .resolved_taken(resolved_taken),
    .squashed(squashed),
    .branch_count(branch_count),
    .taken_count(taken_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [15:0] ins, input logic [11:0] addr);
    bus.instr_valid = 1'b1;
    bus.instr       = ins;
    bus.instr_addr  = addr;
    step();
    bus.instr_valid = 1'b0;
  endtask

  task automatic set_flags(input logic [3:0] f);
    flag_we = 1'b1;
    flag_in = f;
    step();
    flag_we = 1'b0;
  endtask

  // Take the pending redirect and feed two wrong-path instructions.
  task automatic drain();
    bus.redirect_ready = 1'b1;
    step();
    bus.redirect_ready = 1'b0;
    issue(16'h0000, 12'h000);
    issue(16'h0000, 12'h000);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1;
    flag_we = 1'b0;
    flag_in = 4'h0;
    bus.instr_valid    = 1'b0;
    bus.instr          = 16'h0000;
    bus.instr_addr     = 12'h000;
    bus.redirect_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_ready", bus.instr_ready, 1);
    chk("rst_rv", bus.redirect_valid, 0);
    chk("rst_bc", branch_count, 0);
    chk("rst_tc", taken_count, 0);

    // BEQ taken with Z=1: 0x010 + 1 + 5 = 0x016
    set_flags(4'b0100);
    issue(16'hB805, 12'h010);
    chk("beq_rv", bus.redirect_valid, 1);
    chk("beq_addr", bus.redirect_addr, 12'h016);
    chk("beq_res", resolved, 1);
    chk("beq_taken", resolved_taken, 1);
    chk("beq_tc", taken_count, 1);
    chk("beq_bc", branch_count, 1);
    chk("hold_ready", bus.instr_ready, 0);
    // Hold for 3 cycles with an instruction presented that must not be taken.
    bus.instr_valid = 1'b1;
    bus.instr = 16'hB805;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_rv", bus.redirect_valid, 1);
      chk("hold_addr", bus.redirect_addr, 12'h016);
      chk("hold_nores", resolved, 0);
    end
    bus.instr_valid = 1'b0;
    bus.redirect_ready = 1'b1;
    step();
    bus.redirect_ready = 1'b0;
    chk("sq_rv_drop", bus.redirect_valid, 0);
    chk("sq_ready", bus.instr_ready, 1);
    issue(16'hB805, 12'h010);
    chk("sq1_pulse", squashed, 1);
    chk("sq1_nores", resolved, 0);
    chk("sq1_bc", branch_count, 1);
    issue(16'h1234, 12'h011);
    chk("sq2_pulse", squashed, 1);
    step();
    chk("sq_end", squashed, 0);
    issue(16'h0000, 12'h012);
    chk("nb_nosq", squashed, 0);
    chk("nb_nores", resolved, 0);
    chk("nb_bc", branch_count, 1);

    // Reset while holding a redirect.
    issue(16'hB805, 12'h010);
    chk("pre_rst_rv", bus.redirect_valid, 1);
    chk("pre_rst_tc", taken_count, 2);
    rst = 1'b1;
    #1;
    chk("arst_rv", bus.redirect_valid, 0);
    chk("arst_addr", bus.redirect_addr, 0);
    chk("arst_res", resolved, 0);
    chk("arst_bc", branch_count, 0);
    chk("arst_tc", taken_count, 0);
    step();
    rst = 1'b0;
    step();
    chk("arst_ready", bus.instr_ready, 1);
    chk("arst_rv2", bus.redirect_valid, 0);

    // Unsigned cond with wrap: 0x005 + 1 - 128 = 0xF86
    set_flags(4'b0001);
    issue(16'hBC80, 12'h005);
    chk("wrap_rv", bus.redirect_valid, 1);
    chk("wrap_addr", bus.redirect_addr, 12'hF86);
    chk("wrap_tc", taken_count, 1);
    drain();
    set_flags(4'b0000);
    issue(16'hBC80, 12'h005);
    chk("nc_res", resolved, 1);
    chk("nc_taken", resolved_taken, 0);
    chk("nc_rv", bus.redirect_valid, 0);
    chk("nc_bc", branch_count, 2);
    chk("nc_tc", taken_count, 1);

    // Bypass: stored Z=0, Z=1 written in the accept cycle.
    flag_we = 1'b1;
    flag_in = 4'b0100;
    issue(16'hB805, 12'h010);
    flag_we = 1'b0;
    chk("byp_rv", bus.redirect_valid, 1);
    chk("byp_addr", bus.redirect_addr, 12'h016);
    chk("byp_tc", taken_count, 2);
    drain();

    // Never / always.
    issue(16'hBF00, 12'h020);
    chk("nev_res", resolved, 1);
    chk("nev_taken", resolved_taken, 0);
    chk("nev_bc", branch_count, 4);
    chk("nev_rv", bus.redirect_valid, 0);
    issue(16'hBE03, 12'h020);
    chk("alw_taken", resolved_taken, 1);
    chk("alw_addr", bus.redirect_addr, 12'h024);
    chk("alw_bc", branch_count, 5);
    chk("alw_tc", taken_count, 3);
    drain();

    // Saturation: 20 more taken branches.
    for (int i = 0; i < 20; i++) begin
      issue(16'hBE00, 12'h100);
      chk("sat_rv", bus.redirect_valid, 1);
      drain();
    end
    chk("sat_bc", branch_count, 4'hF);
    chk("sat_tc", taken_count, 4'hF);
    issue(16'hBE00, 12'h100);
    chk("sat_res", resolved, 1);
    chk("sat_addr", bus.redirect_addr, 12'h101);
    chk("sat_tc2", taken_count, 4'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
